// File: rtl/string_symbol_scheduler.sv
// Round-robin scheduler sharing one byte-to-bipolar-symbol serializer between NUM_REQ
// character streams; bytes go out MSB-first as a logic bit and as a signed +/-1.0 value.
module string_symbol_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FRAC_W  = 14,
   parameter int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [8*NUM_REQ-1:0]     req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     sym_valid,
   input  logic                     sym_ready,
   output logic                     sym_bit,
   output logic signed [DATA_W-1:0] sym_real,
   output logic                     sym_last,
   output logic [SRC_W-1:0]         sym_src,
   output logic                     busy
);

   typedef enum logic [1:0] {StIdle, StFetch, StShift} state_e;

   localparam logic [DATA_W-1:0] SymOne  = DATA_W'(1) << FRAC_W;
   localparam logic [DATA_W-1:0] SymZero = ~SymOne + DATA_W'(1);

   state_e           state_q, state_d;
   logic [SRC_W-1:0] grant_q, grant_d;
   logic [SRC_W-1:0] last_grant_q, last_grant_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             last_byte_q, last_byte_d;

   logic             found;
   logic [SRC_W-1:0] winner;
   logic [SRC_W-1:0] cand;
   logic             gnt_valid;
   logic             gnt_last;
   logic [7:0]       gnt_byte;

   // First valid requester at or after last_grant+1, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = SRC_W'((int'(last_grant_q) + 1 + i) % int'(NUM_REQ));
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      gnt_byte  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (SRC_W'(i) == grant_q) begin
            gnt_valid = req_valid[i];
            gnt_last  = req_last[i];
            gnt_byte  = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      last_byte_d  = last_byte_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = winner;
               state_d = StFetch;
            end
         end
         StFetch: begin
            // Grant stays locked here until the owner supplies its next byte.
            if (gnt_valid) begin
               shreg_d     = gnt_byte;
               last_byte_d = gnt_last;
               bit_cnt_d   = '0;
               state_d     = StShift;
            end
         end
         StShift: begin
            if (sym_ready) begin
               shreg_d   = {shreg_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (last_byte_q) begin
                     last_grant_d = grant_q;
                     state_d      = StIdle;
                  end else begin
                     state_d = StFetch;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= SRC_W'(NUM_REQ - 1);
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         last_byte_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         last_byte_q  <= last_byte_d;
      end
   end

   // All outputs decode registered state only.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req_ready[i] = (state_q == StFetch) && (SRC_W'(i) == grant_q);
      end
      sym_valid = (state_q == StShift);
      sym_bit   = sym_valid && shreg_q[7];
      sym_real  = !sym_valid ? '0 : (shreg_q[7] ? SymOne : SymZero);
      sym_last  = sym_valid && last_byte_q && (bit_cnt_q == 3'd7);
      sym_src   = sym_valid ? grant_q : '0;
      busy      = (state_q != StIdle);
   end

endmodule
